// File: rtl/bch_err_correct_if.sv
// Stream bundle for the BCH correction stage: received data, locator degree, Chien error flags
// and the corrected output with per-frame status.
interface bch_err_correct_if #(
   parameter int unsigned C_THREAD_NUM = 8,
   parameter int unsigned C_DEG_WIDTH  = 6
);
   logic [C_THREAD_NUM-1:0] I_data;
   logic                    I_data_v;
   logic                    I_data_sof;
   logic                    I_data_eof;
   logic [C_DEG_WIDTH-1:0]  I_deg;
   logic                    I_deg_v;
   logic [C_THREAD_NUM-1:0] I_err;
   logic                    I_err_v;
   logic                    I_err_sof;
   logic                    I_err_eof;
   logic [C_THREAD_NUM-1:0] O_data;
   logic                    O_data_v;
   logic                    O_data_sof;
   logic                    O_data_eof;
   logic [C_DEG_WIDTH-1:0]  O_err_cnt;
   logic                    O_fail;
   logic                    O_ovf;
   logic                    O_unf;

   modport master (
      output I_data, I_data_v, I_data_sof, I_data_eof, I_deg, I_deg_v,
             I_err, I_err_v, I_err_sof, I_err_eof,
      input  O_data, O_data_v, O_data_sof, O_data_eof, O_err_cnt, O_fail, O_ovf, O_unf
   );

   modport slave (
      input  I_data, I_data_v, I_data_sof, I_data_eof, I_deg, I_deg_v,
             I_err, I_err_v, I_err_sof, I_err_eof,
      output O_data, O_data_v, O_data_sof, O_data_eof, O_err_cnt, O_fail, O_ovf, O_unf
   );
endinterface

// File: rtl/bch_err_correct.sv
// BCH final correction: ping-pong buffers received codewords and XORs the Chien error stream onto
// them, reporting the flipped-bit count and a decode-failure flag per frame.
module bch_err_correct #(
   parameter int unsigned C_THREAD_NUM   = 8,
   parameter int unsigned C_TOTALBIT_NUM = 8832,
   parameter int unsigned C_BEAT_NUM     = (C_TOTALBIT_NUM + C_THREAD_NUM - 1) / C_THREAD_NUM,
   parameter int unsigned C_COEF_NUM     = 43,
   parameter int unsigned C_DEG_WIDTH    = 6
) (
   input logic              I_clk,
   input logic              I_rst_n,
   bch_err_correct_if.slave bus
);
   localparam int unsigned AW = (C_BEAT_NUM > 1) ? $clog2(C_BEAT_NUM) : 1;
   localparam logic [AW-1:0] LastAddr = AW'(C_BEAT_NUM - 1);
   localparam logic [C_DEG_WIDTH-1:0] CntMax = '1;

   if (C_COEF_NUM > (2 ** C_DEG_WIDTH) - 1) begin : g_deg_width_chk
      $error("C_DEG_WIDTH too narrow to hold C_COEF_NUM");
   end

   typedef enum logic [1:0] {StEmpty, StWriting, StFull, StReading} bank_st_e;

   bank_st_e                bank_q [2];
   bank_st_e                bank_d [2];
   logic                    wsel_q, wsel_d, wr_act_q, wr_act_d, wr_en;
   logic [AW-1:0]           wr_addr_q, wr_addr_d, wr_addr;
   logic                    rsel_q, rsel_d, rd_act_q, rd_act_d, rd_en;
   logic [AW-1:0]           rd_addr_q, rd_addr_d, rd_addr;
   logic [C_DEG_WIDTH-1:0]  deg_hold_q, deg_act_q, deg_act_d;
   logic                    ovf_q, ovf_d, unf_q, unf_d;

   logic [C_THREAD_NUM-1:0] mem_q [2][C_BEAT_NUM];
   logic [C_THREAD_NUM-1:0] rdata_q;
   logic                    p1_v_q, p1_sof_q, p1_eof_q;
   logic [C_THREAD_NUM-1:0] p1_err_q;
   logic [C_DEG_WIDTH-1:0]  cnt_q, cnt_d;
   logic [31:0]             pc, acc_sum;

   logic [C_THREAD_NUM-1:0] o_data_q;
   logic                    o_v_q, o_sof_q, o_eof_q, o_fail_q;
   logic [C_DEG_WIDTH-1:0]  o_cnt_q;

   function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
      return (a == LastAddr) ? a : a + AW'(1);
   endfunction

   always_comb begin
      bank_d    = bank_q;
      wsel_d    = wsel_q;
      wr_act_d  = wr_act_q;
      wr_addr_d = wr_addr_q;
      wr_addr   = wr_addr_q;
      wr_en     = 1'b0;
      ovf_d     = 1'b0;
      rsel_d    = rsel_q;
      rd_act_d  = rd_act_q;
      rd_addr_d = rd_addr_q;
      rd_addr   = rd_addr_q;
      rd_en     = 1'b0;
      unf_d     = 1'b0;
      deg_act_d = deg_act_q;

      // Write side: a sof on a non-empty target bank drops the frame; later beats find
      // wr_act_q low and fall through untouched.
      if (bus.I_data_v) begin
         if (bus.I_data_sof) begin
            if (wr_act_q || bank_q[wsel_q] == StEmpty) begin
               wr_en            = 1'b1;
               wr_addr          = '0;
               wr_addr_d        = sat_inc('0);
               wr_act_d         = 1'b1;
               bank_d[wsel_q]   = StWriting;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (wr_act_q) begin
            wr_en     = 1'b1;
            wr_addr_d = sat_inc(wr_addr_q);
         end
         if (bus.I_data_eof && wr_en) begin
            bank_d[wsel_q] = StFull;
            wsel_d         = ~wsel_q;
            wr_act_d       = 1'b0;
         end
      end

      // Read side mirrors the write side; state exclusion keeps the two on different banks.
      if (bus.I_err_v) begin
         if (bus.I_err_sof) begin
            if (rd_act_q || bank_q[rsel_q] == StFull) begin
               rd_en          = 1'b1;
               rd_addr        = '0;
               rd_addr_d      = sat_inc('0);
               rd_act_d       = 1'b1;
               bank_d[rsel_q] = StReading;
               deg_act_d      = deg_hold_q;
            end else begin
               unf_d = 1'b1;
            end
         end else if (rd_act_q) begin
            rd_en     = 1'b1;
            rd_addr_d = sat_inc(rd_addr_q);
         end
         if (bus.I_err_eof && rd_en) begin
            bank_d[rsel_q] = StEmpty;
            rsel_d         = ~rsel_q;
            rd_act_d       = 1'b0;
         end
      end
   end

   always_comb begin
      pc = '0;
      for (int i = 0; i < int'(C_THREAD_NUM); i++) begin
         pc = pc + 32'(p1_err_q[i]);
      end
      acc_sum = (p1_sof_q ? 32'd0 : 32'(cnt_q)) + pc;
      cnt_d   = (acc_sum > 32'(CntMax)) ? CntMax : acc_sum[C_DEG_WIDTH-1:0];
   end

   // Buffer RAM: contents are deliberately not reset.
   always_ff @(posedge I_clk) begin
      if (wr_en) mem_q[wsel_q][wr_addr] <= bus.I_data;
      if (rd_en) rdata_q <= mem_q[rsel_q][rd_addr];
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         bank_q[0]  <= StEmpty;
         bank_q[1]  <= StEmpty;
         wsel_q     <= 1'b0;
         wr_act_q   <= 1'b0;
         wr_addr_q  <= '0;
         rsel_q     <= 1'b0;
         rd_act_q   <= 1'b0;
         rd_addr_q  <= '0;
         deg_hold_q <= '0;
         deg_act_q  <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         p1_v_q     <= 1'b0;
         p1_sof_q   <= 1'b0;
         p1_eof_q   <= 1'b0;
         p1_err_q   <= '0;
         cnt_q      <= '0;
         o_data_q   <= '0;
         o_v_q      <= 1'b0;
         o_sof_q    <= 1'b0;
         o_eof_q    <= 1'b0;
         o_cnt_q    <= '0;
         o_fail_q   <= 1'b0;
      end else begin
         bank_q    <= bank_d;
         wsel_q    <= wsel_d;
         wr_act_q  <= wr_act_d;
         wr_addr_q <= wr_addr_d;
         rsel_q    <= rsel_d;
         rd_act_q  <= rd_act_d;
         rd_addr_q <= rd_addr_d;
         deg_act_q <= deg_act_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         if (bus.I_deg_v) deg_hold_q <= bus.I_deg;
         p1_v_q   <= rd_en;
         p1_sof_q <= rd_en & bus.I_err_sof;
         p1_eof_q <= rd_en & bus.I_err_eof;
         p1_err_q <= bus.I_err;
         if (p1_v_q) begin
            cnt_q    <= cnt_d;
            o_data_q <= rdata_q ^ p1_err_q;
         end
         o_v_q   <= p1_v_q;
         o_sof_q <= p1_sof_q;
         o_eof_q <= p1_eof_q;
         // deg_act_q cannot move to the next frame before this eof leaves stage 1.
         if (p1_eof_q) begin
            o_cnt_q  <= cnt_d;
            o_fail_q <= (cnt_d != deg_act_q);
         end
      end
   end

   assign bus.O_data     = o_data_q;
   assign bus.O_data_v   = o_v_q;
   assign bus.O_data_sof = o_sof_q;
   assign bus.O_data_eof = o_eof_q;
   assign bus.O_err_cnt  = o_cnt_q;
   assign bus.O_fail     = o_fail_q;
   assign bus.O_ovf      = ovf_q;
   assign bus.O_unf      = unf_q;
endmodule

// File: tb/tb_bch_err_correct.sv
// Randomized bench for bch_err_correct: frame-level model of the two buffers and the error stream,
// one compare process on every output cycle, plus literal checks on the directed cases.
module tb_bch_err_correct;
   localparam int unsigned TN   = 8;
   localparam int unsigned DW   = 6;
   localparam int          NB   = 1104;
   localparam int          LAST = NB - 1;
   localparam int          StEmpty = 0, StWriting = 1, StFull = 2, StReading = 3;

   logic I_clk = 1'b0;
   logic I_rst_n;
   always #5 I_clk = ~I_clk;

   bch_err_correct_if #(.C_THREAD_NUM(TN), .C_DEG_WIDTH(DW)) bus ();

   bch_err_correct #(
      .C_THREAD_NUM   (TN),
      .C_TOTALBIT_NUM (8832),
      .C_COEF_NUM     (43),
      .C_DEG_WIDTH    (DW)
   ) dut (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .bus     (bus)
   );

   typedef struct {
      longint     cyc;
      logic [7:0] data;
      bit         sof;
      bit         eof;
      int         cnt;
      bit         fail;
   } exp_t;

   int         tests = 0;
   int         fails = 0;
   longint     cyc = 0;
   exp_t       expq [$];
   logic [7:0] m_mem [2][NB];
   int         m_bank [2];
   int         m_wsel, m_rsel, m_deg_hold;
   int         exp_ovf = 0, exp_unf = 0, obs_ovf = 0, obs_unf = 0;
   int         held_cnt = 0;
   bit         held_fail = 1'b0;
   int         cap_cnt, cap_fail;
   logic [7:0] cap_first, wr_first;
   bit         chk_en = 1'b0;

   always @(posedge I_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic model_reset();
      m_bank[0]  = StEmpty;
      m_bank[1]  = StEmpty;
      m_wsel     = 0;
      m_rsel     = 0;
      m_deg_hold = 0;
      held_cnt   = 0;
      held_fail  = 1'b0;
      expq.delete();
   endtask

   task automatic clear_inputs();
      bus.I_data = '0; bus.I_data_v = 1'b0; bus.I_data_sof = 1'b0; bus.I_data_eof = 1'b0;
      bus.I_deg = '0;  bus.I_deg_v = 1'b0;
      bus.I_err = '0;  bus.I_err_v = 1'b0;  bus.I_err_sof = 1'b0;  bus.I_err_eof = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_o_data"}, bus.O_data, 0);
      chk({tag, "_o_data_v"}, bus.O_data_v, 0);
      chk({tag, "_o_data_sof"}, bus.O_data_sof, 0);
      chk({tag, "_o_data_eof"}, bus.O_data_eof, 0);
      chk({tag, "_o_err_cnt"}, bus.O_err_cnt, 0);
      chk({tag, "_o_fail"}, bus.O_fail, 0);
      chk({tag, "_o_ovf"}, bus.O_ovf, 0);
      chk({tag, "_o_unf"}, bus.O_unf, 0);
   endtask

   // Called just after a clock edge; asserts reset between edges and checks it bites at once.
   task automatic do_reset();
      #2;
      I_rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      check_outputs_zero("midrst");
      repeat (2) @(posedge I_clk);
      #3;
      I_rst_n = 1'b1;
      tick();
   endtask

   task automatic write_frame(input int nbeats, input int gap_pct);
      bit acc = 1'b0;
      int w = 0;
      for (int i = 0; i < nbeats; i++) begin
         logic [7:0] d;
         while ($urandom_range(99) < gap_pct) tick();
         d = 8'($urandom);
         if (i == 0) begin
            w   = m_wsel;
            acc = (m_bank[w] == StEmpty);
            wr_first = d;
            if (acc) m_bank[w] = StWriting;
            else exp_ovf++;
         end
         if (acc) m_mem[w][(i > LAST) ? LAST : i] = d;
         if (acc && i == nbeats - 1) begin
            m_bank[w] = StFull;
            m_wsel ^= 1;
         end
         bus.I_data = d; bus.I_data_v = 1'b1;
         bus.I_data_sof = (i == 0); bus.I_data_eof = (i == nbeats - 1);
         tick();
         bus.I_data_v = 1'b0; bus.I_data_sof = 1'b0; bus.I_data_eof = 1'b0;
      end
   endtask

   // mode 0: no flags, 1: bits 0,7 of beat 0 and bit 3 of the last beat, 2: sparse, 3: dense
   task automatic err_frame(input int mode, input int deg, input int gap_pct, input int rst_beat);
      bit acc = 1'b0;
      int r = 0, cnt = 0, deg_act = 0;
      bus.I_deg = DW'(deg); bus.I_deg_v = 1'b1;
      m_deg_hold = deg;
      tick();
      bus.I_deg_v = 1'b0;
      for (int i = 0; i < NB; i++) begin
         logic [7:0] e;
         exp_t x;
         if (i != 0) while ($urandom_range(99) < gap_pct) tick();
         case (mode)
            1: e = (i == 0) ? 8'h81 : (i == NB - 1) ? 8'h08 : 8'h00;
            2: e = ($urandom_range(199) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
            3: e = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            default: e = 8'h00;
         endcase
         if (i == 0) begin
            r   = m_rsel;
            acc = (m_bank[r] == StFull);
            if (acc) begin
               m_bank[r] = StReading;
               deg_act   = m_deg_hold;
               cnt       = 0;
            end else begin
               exp_unf++;
            end
         end
         if (acc) begin
            cnt = cnt + $countones(e);
            if (cnt > 63) cnt = 63;
            x.cyc  = cyc + 2;
            x.data = m_mem[r][i] ^ e;
            x.sof  = (i == 0);
            x.eof  = (i == NB - 1);
            x.cnt  = cnt;
            x.fail = (cnt != deg_act);
            expq.push_back(x);
            if (i == NB - 1) begin
               m_bank[r] = StEmpty;
               m_rsel ^= 1;
            end
         end
         bus.I_err = e; bus.I_err_v = 1'b1;
         bus.I_err_sof = (i == 0); bus.I_err_eof = (i == NB - 1);
         tick();
         bus.I_err_v = 1'b0; bus.I_err_sof = 1'b0; bus.I_err_eof = 1'b0; bus.I_err = '0;
         if (i == rst_beat) begin
            do_reset();
            return;
         end
      end
   endtask

   task automatic drain(input string tag);
      repeat (4) tick();
      chk({tag, "_drain"}, expq.size(), 0);
   endtask

   always @(negedge I_clk) begin
      exp_t e;
      if (chk_en && I_rst_n) begin
         if (bus.O_data_v) begin
            if (expq.size() == 0) begin
               chk("spurious_o_data_v", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("o_data_v_cycle", cyc, e.cyc);
               chk("o_data", bus.O_data, e.data);
               chk("o_data_sof", bus.O_data_sof, e.sof);
               chk("o_data_eof", bus.O_data_eof, e.eof);
               if (e.sof) cap_first = bus.O_data;
               if (e.eof) begin
                  held_cnt  = e.cnt;
                  held_fail = e.fail;
                  cap_cnt   = int'(bus.O_err_cnt);
                  cap_fail  = int'(bus.O_fail);
               end
            end
         end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            chk("missing_o_data_v", 0, 1);
            e = expq.pop_front();
         end
         chk("o_err_cnt", bus.O_err_cnt, held_cnt);
         chk("o_fail", bus.O_fail, held_fail);
         if (bus.O_ovf) obs_ovf++;
         if (bus.O_unf) obs_unf++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int o0, u0;
      clear_inputs();
      model_reset();
      I_rst_n = 1'b1;
      #1 I_rst_n = 1'b0;
      #1 check_outputs_zero("reset");
      repeat (3) @(posedge I_clk);
      #3 I_rst_n = 1'b1;
      tick();
      chk_en = 1'b1;

      // Clean frame: output mirrors written data.
      cap_cnt = -1; cap_fail = -1;
      write_frame(NB, 10);
      err_frame(0, 0, 10, -1);
      drain("t1");
      chk("t1_err_cnt", cap_cnt, 0);
      chk("t1_fail", cap_fail, 0);

      // Three flips, matching degree.
      cap_cnt = -1; cap_fail = -1;
      write_frame(NB, 0);
      o0 = int'(wr_first);
      err_frame(1, 3, 0, -1);
      drain("t2");
      chk("t2_err_cnt", cap_cnt, 3);
      chk("t2_fail", cap_fail, 0);
      chk("t2_first_beat", cap_first, 8'(o0) ^ 8'h81);

      // Same flips, degree off by one.
      cap_cnt = -1; cap_fail = -1;
      write_frame(NB, 5);
      err_frame(1, 4, 5, -1);
      drain("t3");
      chk("t3_err_cnt", cap_cnt, 3);
      chk("t3_fail", cap_fail, 1);

      // Third back-to-back frame overflows; two error frames then drain the banks in order.
      o0 = obs_ovf;
      write_frame(NB, 0);
      write_frame(NB, 0);
      write_frame(NB, 0);
      repeat (3) tick();
      chk("t4_ovf_pulses", obs_ovf - o0, 1);
      err_frame(2, $urandom_range(43), 5, -1);
      err_frame(2, $urandom_range(43), 5, -1);
      drain("t4");

      // Error stream with nothing buffered.
      u0 = obs_unf;
      err_frame(0, 0, 0, -1);
      drain("t5");
      chk("t5_unf_pulses", obs_unf - u0, 1);

      // Overlong write saturates the address; dense flags saturate the count.
      cap_cnt = -1; cap_fail = -1;
      write_frame(NB + 3, 5);
      err_frame(3, 20, 5, -1);
      drain("t6");
      chk("t6_err_cnt_sat", cap_cnt, 63);
      chk("t6_fail", cap_fail, 1);

      // Overlapped traffic; first pass lines a write eof up with a read sof.
      write_frame(NB, 8);
      for (int k = 0; k < 4; k++) begin
         fork
            write_frame(NB, (k == 0) ? 0 : int'($urandom_range(20)));
            begin
               if (k == 0) repeat (NB - 2) tick();
               err_frame(($urandom_range(1) == 0) ? 2 : 3, $urandom_range(43),
                         (k == 0) ? 0 : int'($urandom_range(20)), -1);
            end
         join
      end
      err_frame(2, $urandom_range(43), 10, -1);
      drain("t7");

      // Reset while output is streaming, then a normal frame from bank 0.
      write_frame(NB, 0);
      err_frame(2, 5, 0, 100);
      chk("t8_queue_flushed", expq.size(), 0);
      cap_cnt = -1; cap_fail = -1;
      write_frame(NB, 10);
      o0 = int'(wr_first);
      err_frame(1, 3, 10, -1);
      drain("t8");
      chk("t8_err_cnt", cap_cnt, 3);
      chk("t8_fail", cap_fail, 0);
      chk("t8_first_beat", cap_first, 8'(o0) ^ 8'h81);

      chk("ovf_total", obs_ovf, exp_ovf);
      chk("unf_total", obs_unf, exp_unf);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
